yuv444to422_pack: RTL and testbench

YUV444TO422_PACK -- requirements
Module: yuv444to422_pack

---
 rtl/yuv444to422_pack.sv | 168 ++++++++++++++++
 tb/tb_yuv444to422_pack.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv444to422_pack.sv
// YUV 4:4:4 to packed YUYV 4:2:2 stream converter: two input pixels become one 32-bit word, two words per output beat.
// Optional macro YUV444TO422_AVG_EN selects rounded averaging of both pixels' chroma instead of taking pixel 0's chroma.
module yuv444to422_pack #(
    parameter int DEST_WIDTH = 3,
    parameter int USER_WIDTH = 8   // must be >= 2*DEST_WIDTH
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  src_t_valid,
    output logic                  src_t_ready,
    input  logic [63:0]           src_t_data,
    input  logic                  src_t_last,
    input  logic [DEST_WIDTH-1:0] src_t_dest,
    input  logic [USER_WIDTH-1:0] src_t_user,
    output logic                  dst_t_valid,
    input  logic                  dst_t_ready,
    output logic [63:0]           dst_t_data,
    output logic                  dst_t_last,
    output logic [DEST_WIDTH-1:0] dst_t_dest,
    output logic [USER_WIDTH-1:0] dst_t_user,
    output logic                  state_dbg
);

    // Both streams: a beat transfers on a rising edge where valid && ready;
    // once valid is raised, data/last/dest/user stay stable until that transfer.

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    localparam logic [31:0] PAD_WORD = 32'h8000_8000;

    state_t                  state_q, state_d;
    logic [31:0]             held_word_q;
    logic [USER_WIDTH-1:0]   held_user_q;
    logic                    out_valid_q;
    logic [63:0]             out_data_q;
    logic                    out_last_q;
    logic [DEST_WIDTH-1:0]   out_dest_q;
    logic [USER_WIDTH-1:0]   out_user_q;

    logic                    out_free;
    logic                    capture_half;
    logic                    load_pair;
    logic                    load_single;

    logic [7:0]              y0_pix;
    logic [7:0]              y1_pix;
    logic [7:0]              u_pix;
    logic [7:0]              v_pix;
    logic [31:0]             yuyv_word;

    assign y0_pix = src_t_data[7:0];
    assign y1_pix = src_t_data[39:32];

`ifdef YUV444TO422_AVG_EN
    logic [8:0] u_sum;
    logic [8:0] v_sum;
    logic       unused_round_bits;

    // Adding 1 before dropping the LSB rounds half up; the 9-bit sum never overflows.
    assign u_sum = {1'b0, src_t_data[15:8]}  + {1'b0, src_t_data[47:40]} + 9'd1;
    assign v_sum = {1'b0, src_t_data[23:16]} + {1'b0, src_t_data[55:48]} + 9'd1;
    assign u_pix = u_sum[8:1];
    assign v_pix = v_sum[8:1];
    assign unused_round_bits = u_sum[0] ^ v_sum[0];
`else
    logic unused_p1_chroma;

    assign u_pix = src_t_data[15:8];
    assign v_pix = src_t_data[23:16];
    assign unused_p1_chroma = ^src_t_data[55:40];
`endif

    logic unused_inputs;
    assign unused_inputs = ^{src_t_data[63:56], src_t_data[31:24], src_t_dest};

    assign yuyv_word = {v_pix, y1_pix, u_pix, y0_pix};

    // The output slot can take a new beat if empty or being drained this cycle.
    assign out_free = !out_valid_q || dst_t_ready;

    always_comb begin
        state_d      = state_q;
        src_t_ready  = 1'b0;
        capture_half = 1'b0;
        load_pair    = 1'b0;
        load_single  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_EMPTY: begin
                    if (!src_t_last) begin
                        // Storing a low half never touches the output slot.
                        src_t_ready = 1'b1;
                        if (src_t_valid) begin
                            capture_half = 1'b1;
                            state_d      = ST_HALF;
                        end
                    end else begin
                        src_t_ready = out_free;
                        if (src_t_valid && out_free) begin
                            load_single = 1'b1;
                        end
                    end
                end
                ST_HALF: begin
                    src_t_ready = out_free;
                    if (src_t_valid && out_free) begin
                        load_pair = 1'b1;
                        state_d   = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            held_word_q <= '0;
            held_user_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_dest_q  <= '0;
            out_user_q  <= '0;
        end else begin
            if (capture_half) begin
                held_word_q <= yuyv_word;
                held_user_q <= src_t_user;
            end
            // Routing always comes from the first beat of the pair.
            if (load_pair) begin
                out_data_q <= {yuyv_word, held_word_q};
                out_last_q <= src_t_last;
                out_dest_q <= held_user_q[DEST_WIDTH-1:0];
                out_user_q <= held_user_q >> DEST_WIDTH;
            end else if (load_single) begin
                out_data_q <= {PAD_WORD, yuyv_word};
                out_last_q <= 1'b1;
                out_dest_q <= src_t_user[DEST_WIDTH-1:0];
                out_user_q <= src_t_user >> DEST_WIDTH;
            end
            if (load_pair || load_single) begin
                out_valid_q <= 1'b1;
            end else if (dst_t_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign dst_t_valid = out_valid_q;
    assign dst_t_data  = out_data_q;
    assign dst_t_last  = out_last_q;
    assign dst_t_dest  = out_dest_q;
    assign dst_t_user  = out_user_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_yuv444to422_pack.sv
// Bench for yuv444to422_pack: constant vector table, hand-built handshake/reset sequences,
// and randomized traffic scored against a packet-level word-pairing model.
module tb_yuv444to422_pack;

    localparam int DW = 3;
    localparam int UW = 8;
    localparam int EW = 64 + 1 + DW + UW;

`ifdef YUV444TO422_AVG_EN
    localparam logic [63:0] E0 = 64'hC890B8C0_48103840;
    localparam logic [63:0] E1 = 64'h80008000_4D113C44;
    localparam logic [63:0] E2 = 64'hDBA1CAD1_80018002;
    localparam logic [63:0] E3 = 64'h0055FF66_FFAA1100;
`else
    localparam logic [63:0] E0 = 64'hE090D0C0_60105040;
    localparam logic [63:0] E1 = 64'h80008000_66115544;
    localparam logic [63:0] E2 = 64'hF3A1E2D1_FF01FF02;
    localparam logic [63:0] E3 = 64'h0055FF66_FFAA1000;
`endif

    logic          aclk = 1'b0;
    logic          rst = 1'b1;
    logic          src_t_valid = 1'b0;
    logic          src_t_ready;
    logic [63:0]   src_t_data = '0;
    logic          src_t_last = 1'b0;
    logic [DW-1:0] src_t_dest = '0;
    logic [UW-1:0] src_t_user = '0;
    logic          dst_t_valid;
    logic          dst_t_ready = 1'b1;
    logic [63:0]   dst_t_data;
    logic          dst_t_last;
    logic [DW-1:0] dst_t_dest;
    logic [UW-1:0] dst_t_user;
    logic          state_dbg;
    logic [EW-1:0] dut_vec;

    yuv444to422_pack #(.DEST_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .aclk(aclk), .rst(rst),
        .src_t_valid(src_t_valid), .src_t_ready(src_t_ready), .src_t_data(src_t_data),
        .src_t_last(src_t_last), .src_t_dest(src_t_dest), .src_t_user(src_t_user),
        .dst_t_valid(dst_t_valid), .dst_t_ready(dst_t_ready), .dst_t_data(dst_t_data),
        .dst_t_last(dst_t_last), .dst_t_dest(dst_t_dest), .dst_t_user(dst_t_user),
        .state_dbg(state_dbg)
    );

    assign dut_vec = {dst_t_data, dst_t_last, dst_t_dest, dst_t_user};

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int out_cnt = 0;
    logic [EW-1:0] exp_q[$];
    logic [31:0]   pend_w[$];
    logic [UW-1:0] pend_u[$];

    typedef struct {
        logic [63:0]   d0;
        logic [63:0]   d1;
        logic [UW-1:0] user;
        logic          one_beat;
        logic          last1;
        logic [EW-1:0] exp_out;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] word_of(input logic [63:0] d);
        logic [31:0] u;
        logic [31:0] v;
`ifdef YUV444TO422_AVG_EN
        u = (32'(d[15:8]) + 32'(d[47:40]) + 1) / 2;
        v = (32'(d[23:16]) + 32'(d[55:48]) + 1) / 2;
`else
        u = 32'(d[15:8]);
        v = 32'(d[23:16]);
`endif
        return {v[7:0], d[39:32], u[7:0], d[7:0]};
    endfunction

    function automatic logic [EW-1:0] pack_out(input logic [63:0] data, input logic last,
                                               input logic [UW-1:0] user0);
        logic [UW-1:0] upper;
        upper = user0 / UW'(1 << DW);
        return {data, last, user0[DW-1:0], upper};
    endfunction

    task automatic model_accept(input logic [63:0] d, input logic last, input logic [UW-1:0] u);
        logic [63:0] data;
        pend_w.push_back(word_of(d));
        pend_u.push_back(u);
        if (last || pend_w.size() == 2) begin
            if (pend_w.size() == 2) data = {pend_w[1], pend_w[0]};
            else                    data = {32'h8000_8000, pend_w[0]};
            exp_q.push_back(pack_out(data, last, pend_u[0]));
            pend_w.delete();
            pend_u.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge aclk) begin
        if (chk_en && !rst) begin
            if (src_t_valid && src_t_ready) model_accept(src_t_data, src_t_last, src_t_user);
            if (dst_t_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h expected no beat at %0t", dut_vec, $time);
                end else begin
                    chk("sb_out", dut_vec, exp_q[0]);
                    if (dst_t_ready) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [63:0] d, input logic last, input logic [UW-1:0] u);
        bit ok;
        ok = 1'b0;
        src_t_valid = 1'b1;
        src_t_data  = d;
        src_t_last  = last;
        src_t_user  = u;
        src_t_dest  = DW'($urandom_range(0, 7));
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (src_t_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no src_t_ready expected acceptance at %0t", $time);
        end
        @(posedge aclk);
        #1;
        src_t_valid = 1'b0;
        src_t_last  = 1'b0;
    endtask

    task automatic wait_out(output logic [EW-1:0] v);
        v = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (dst_t_valid) begin
                v = dut_vec;
                break;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge aclk);
        #1;
        rst = 1'b1;
        @(posedge aclk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [EW-1:0] got;
        logic [63:0]   a0, a1, b0, b1;
        logic [63:0]   exp_a, exp_b;
        int            snap;
        int            kk;
        bit            src_done;

        tbl[0] = '{64'h00302010_00605040, 64'h00B0A090_00E0D0C0, 8'h2B, 1'b0, 1'b0,
                   {E0, 1'b0, 3'd3, 8'h05}};
        tbl[1] = '{64'h00332211_00665544, 64'h0, 8'hFF, 1'b1, 1'b1,
                   {E1, 1'b1, 3'd7, 8'h1F}};
        tbl[2] = '{64'hFF000001_FFFFFF02, 64'h12C3B2A1_34F3E2D1, 8'h96, 1'b0, 1'b1,
                   {E2, 1'b1, 3'd6, 8'h12}};
        tbl[3] = '{64'h00FF11AA_00FF1000, 64'h0000FF55_0000FF66, 8'h00, 1'b0, 1'b0,
                   {E3, 1'b0, 3'd0, 8'h00}};

        // reset values; a valid non-last beat would otherwise be accepted
        rst         = 1'b1;
        src_t_valid = 1'b1;
        src_t_last  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_src_ready", EW'(src_t_ready), EW'(0));
        chk("rst_dst_valid", EW'(dst_t_valid), EW'(0));
        chk("rst_dst_fields", dut_vec, '0);
        chk("rst_state", EW'(state_dbg), EW'(0));
        @(posedge aclk);
        #1;
        rst         = 1'b0;
        src_t_valid = 1'b0;

        // table vectors
        dst_t_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(tbl[i].d0, tbl[i].one_beat, tbl[i].user);
            if (!tbl[i].one_beat) send_beat(tbl[i].d1, tbl[i].last1, tbl[i].user);
            wait_out(got);
            chk($sformatf("tbl_out_%0d", i), got, tbl[i].exp_out);
            chk($sformatf("tbl_state_%0d", i), EW'(state_dbg), EW'(0));
        end

        // backpressure: output pending, HALF must stall, EMPTY first beat still accepted
        a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        exp_a = {word_of(a1), word_of(a0)};
        exp_b = {word_of(b1), word_of(b0)};
        dst_t_ready = 1'b0;
        send_beat(a0, 1'b0, 8'h11);
        send_beat(a1, 1'b0, 8'h11);
        send_beat(b0, 1'b0, 8'h22);
        src_t_valid = 1'b1;
        src_t_data  = b1;
        src_t_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_src_ready", EW'(src_t_ready), EW'(0));
            chk("bp_dst_valid", EW'(dst_t_valid), EW'(1));
            chk("bp_dst_data", EW'(dst_t_data), EW'(exp_a));
        end
        @(posedge aclk);
        #1;
        dst_t_ready = 1'b1;
        @(negedge aclk);
        chk("bp_release_ready", EW'(src_t_ready), EW'(1));
        chk("bp_release_data", EW'(dst_t_data), EW'(exp_a));
        @(posedge aclk);
        #1;
        src_t_valid = 1'b0;
        @(negedge aclk);
        chk("bp_next_valid", EW'(dst_t_valid), EW'(1));
        chk("bp_next_data", EW'(dst_t_data), EW'(exp_b));
        @(posedge aclk);
        #1;

        // reset in HALF discards the held word
        send_beat({$urandom, $urandom}, 1'b0, 8'h33);
        @(negedge aclk);
        chk("half_state", EW'(state_dbg), EW'(1));
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("rst_half_no_out", EW'(dst_t_valid), EW'(0));
        end
        chk("rst_half_state", EW'(state_dbg), EW'(0));
        @(posedge aclk);
        #1;
        a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
        send_beat(a0, 1'b0, 8'h44);
        send_beat(a1, 1'b1, 8'h44);
        wait_out(got);
        chk("after_rst_out", got, pack_out({word_of(a1), word_of(a0)}, 1'b1, 8'h44));

        // reset with a pending output beat discards it
        dst_t_ready = 1'b0;
        send_beat({$urandom, $urandom}, 1'b0, 8'h55);
        send_beat({$urandom, $urandom}, 1'b0, 8'h55);
        @(negedge aclk);
        chk("pend_valid", EW'(dst_t_valid), EW'(1));
        pulse_reset();
        dst_t_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("rst_pend_no_out", EW'(dst_t_valid), EW'(0));
        end
        @(posedge aclk);
        #1;

        // full throughput: 16 beats back to back, output on every second cycle
        chk_en      = 1'b1;
        dst_t_ready = 1'b1;
        src_t_valid = 1'b1;
        kk = 0;
        for (int b = 0; b < 16; b++) begin
            src_t_data = {$urandom, $urandom};
            src_t_last = (b == 15);
            src_t_user = UW'($urandom_range(0, 255));
            @(negedge aclk);
            chk("tput_ready", EW'(src_t_ready), EW'(1));
            chk("tput_valid", EW'(dst_t_valid), EW'((kk % 2 == 0) && kk >= 2 && kk <= 16));
            kk++;
            @(posedge aclk);
            #1;
        end
        src_t_valid = 1'b0;
        src_t_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("tput_valid", EW'(dst_t_valid), EW'((kk % 2 == 0) && kk >= 2 && kk <= 16));
            kk++;
        end
        @(posedge aclk);
        #1;

        // three-beat packet: one pair plus one padded beat
        snap = out_cnt;
        send_beat({$urandom, $urandom}, 1'b0, 8'h6A);
        send_beat({$urandom, $urandom}, 1'b0, 8'h6A);
        send_beat({$urandom, $urandom}, 1'b1, 8'h7B);
        repeat (4) @(posedge aclk);
        #1;
        chk("three_beat_outs", EW'(out_cnt - snap), EW'(2));

        // randomized traffic with random backpressure
        src_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 120; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge aclk);
                        #1;
                    end
                    send_beat({$urandom, $urandom}, (n == 119) || ($urandom_range(0, 3) == 0),
                              UW'($urandom_range(0, 255)));
                end
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    @(posedge aclk);
                    #1;
                    dst_t_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        dst_t_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge aclk);
        @(negedge aclk);
        chk("drain_empty", EW'(exp_q.size()), EW'(0));
        chk("final_state", EW'(state_dbg), EW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
